// File: rtl/mac_result_accumulator_if.sv
// Handshake/bus bundle between the MAC datapath, the accumulator and the Avalon read path.
// The slave side is the accumulator; the master side is the upstream/readout logic.
interface mac_result_accumulator_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
);
  logic                          clear_i;
  logic                          res_valid_i;
  logic [DATA_WIDTH-1:0]         res_data_i;
  logic                          res_last_i;
  logic [DATA_WIDTH-1:0]         bias_i;
  logic                          relu_en_i;
  logic                          stall_o;
  logic                          out_rd_i;
  logic [DATA_WIDTH-1:0]         out_data_o;
  logic                          out_empty_o;
  logic                          out_full_o;
  logic [$clog2(FIFO_DEPTH):0]   out_count_o;
  logic                          ovf_o;

  modport master (
    output clear_i, res_valid_i, res_data_i, res_last_i, bias_i, relu_en_i, out_rd_i,
    input  stall_o, out_data_o, out_empty_o, out_full_o, out_count_o, ovf_o
  );

  modport slave (
    input  clear_i, res_valid_i, res_data_i, res_last_i, bias_i, relu_en_i, out_rd_i,
    output stall_o, out_data_o, out_empty_o, out_full_o, out_count_o, ovf_o
  );
endinterface

// File: rtl/mac_result_accumulator.sv
// Sums MAC partial results per pixel, adds bias (optional ReLU via ACC_RESULT_RELU_EN),
// and queues finished pixels in a show-ahead FIFO, stalling the MAC reader when busy.
module mac_result_accumulator #(
  parameter int DATA_WIDTH       = 32,
  parameter int TERMS_PER_OUTPUT = 16,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic clk,
  input  logic reset,
  mac_result_accumulator_if.slave bus
);

  localparam int CNT_W  = $clog2(TERMS_PER_OUTPUT) + 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FINAL = 2'd2,
    PUSH  = 2'd3
  } state_t;

  // Signed add clamped to the representable range; MSB of the result flags a clamp.
  function automatic logic [DATA_WIDTH:0] satAdd(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [DATA_WIDTH:0] sum;
    sum = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
      if (sum[DATA_WIDTH]) begin
        satAdd = {1'b1, 1'b1, {(DATA_WIDTH-1){1'b0}}};
      end else begin
        satAdd = {1'b1, 1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
    end else begin
      satAdd = {1'b0, sum[DATA_WIDTH-1:0]};
    end
  endfunction

  state_t                  state_r, nextState_s;
  logic [DATA_WIDTH-1:0]   acc_r;
  logic [DATA_WIDTH-1:0]   post_r;
  logic [CNT_W-1:0]        termCnt_r;
  logic                    ovf_r;
  logic [DATA_WIDTH-1:0]   mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]        wrPtr_r, rdPtr_r;
  logic [FCNT_W-1:0]       fifoCnt_r;

  logic                    syncClr_s;
  logic [CNT_W-1:0]        termCntNext_s;
  logic                    lastTerm_s;
  logic                    fifoFull_s, fifoEmpty_s;
  logic                    popReq_s, pushReq_s;
  logic [DATA_WIDTH:0]     accSat_s, postSat_s;
  logic [DATA_WIDTH-1:0]   postVal_s;
  logic                    ovfSet_s;
  logic                    stall_s;
  logic [DATA_WIDTH-1:0]   headData_s;

  assign syncClr_s     = reset | bus.clear_i;
  assign termCntNext_s = termCnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
  assign lastTerm_s    = bus.res_last_i || (termCntNext_s == CNT_W'(TERMS_PER_OUTPUT));
  assign fifoFull_s    = (fifoCnt_r == FCNT_W'(FIFO_DEPTH));
  assign fifoEmpty_s   = (fifoCnt_r == {FCNT_W{1'b0}});
  assign popReq_s      = bus.out_rd_i && !fifoEmpty_s;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept the pixel.
  assign pushReq_s     = (state_r == PUSH) && (!fifoFull_s || bus.out_rd_i);
  assign accSat_s      = satAdd(acc_r, bus.res_data_i);
  assign postSat_s     = satAdd(acc_r, bus.bias_i);

`ifdef ACC_RESULT_RELU_EN
  // Post-bias value with optional ReLU clamp of negative results.
  always_comb begin
    if (bus.relu_en_i && postSat_s[DATA_WIDTH-1]) begin
      postVal_s = {DATA_WIDTH{1'b0}};
    end else begin
      postVal_s = postSat_s[DATA_WIDTH-1:0];
    end
  end
`else
  logic unusedRelu_s;
  assign unusedRelu_s = bus.relu_en_i;
  assign postVal_s    = postSat_s[DATA_WIDTH-1:0];
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (syncClr_s) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Next-state logic.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.res_valid_i) begin
          if (bus.res_last_i || (TERMS_PER_OUTPUT == 1)) begin
            nextState_s = FINAL;
          end else begin
            nextState_s = ACCUM;
          end
        end else begin
          nextState_s = IDLE;
        end
      end
      ACCUM: begin
        if (bus.res_valid_i && lastTerm_s) begin
          nextState_s = FINAL;
        end else begin
          nextState_s = ACCUM;
        end
      end
      FINAL: nextState_s = PUSH;
      PUSH: begin
        if (pushReq_s) begin
          nextState_s = IDLE;
        end else begin
          nextState_s = PUSH;
        end
      end
      default: nextState_s = IDLE;
    endcase
  end

  // FSM-derived outputs: stall and error-set conditions.
  always_comb begin
    stall_s  = (state_r == FINAL) || (state_r == PUSH) ||
               (fifoCnt_r >= FCNT_W'(FIFO_DEPTH - 1));
    ovfSet_s = 1'b0;
    case (state_r)
      ACCUM:   ovfSet_s = bus.res_valid_i && accSat_s[DATA_WIDTH];
      FINAL:   ovfSet_s = postSat_s[DATA_WIDTH] || bus.res_valid_i;
      PUSH:    ovfSet_s = bus.res_valid_i;
      default: ovfSet_s = 1'b0;
    endcase
  end

  // Accumulator, term counter, post-bias register and sticky error flag.
  always_ff @(posedge clk) begin
    if (syncClr_s) begin
      acc_r     <= {DATA_WIDTH{1'b0}};
      termCnt_r <= {CNT_W{1'b0}};
      post_r    <= {DATA_WIDTH{1'b0}};
      ovf_r     <= 1'b0;
    end else begin
      ovf_r <= ovf_r | ovfSet_s;
      case (state_r)
        IDLE: begin
          if (bus.res_valid_i) begin
            acc_r     <= bus.res_data_i;
            termCnt_r <= {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ACCUM: begin
          if (bus.res_valid_i) begin
            acc_r     <= accSat_s[DATA_WIDTH-1:0];
            termCnt_r <= termCntNext_s;
          end
        end
        FINAL: post_r <= postVal_s;
        PUSH: begin
          if (pushReq_s) begin
            acc_r     <= {DATA_WIDTH{1'b0}};
            termCnt_r <= {CNT_W{1'b0}};
          end
        end
        default: acc_r <= acc_r;
      endcase
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (syncClr_s) begin
      wrPtr_r   <= {PTR_W{1'b0}};
      rdPtr_r   <= {PTR_W{1'b0}};
      fifoCnt_r <= {FCNT_W{1'b0}};
    end else begin
      if (pushReq_s) begin
        wrPtr_r <= wrPtr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (popReq_s) begin
        rdPtr_r <= rdPtr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      case ({pushReq_s, popReq_s})
        2'b10:   fifoCnt_r <= fifoCnt_r + {{(FCNT_W-1){1'b0}}, 1'b1};
        2'b01:   fifoCnt_r <= fifoCnt_r - {{(FCNT_W-1){1'b0}}, 1'b1};
        default: fifoCnt_r <= fifoCnt_r;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (pushReq_s && !syncClr_s) begin
      mem_r[wrPtr_r] <= post_r;
    end
  end

  // Show-ahead head word, forced to zero when empty.
  always_comb begin
    if (fifoEmpty_s) begin
      headData_s = {DATA_WIDTH{1'b0}};
    end else begin
      headData_s = mem_r[rdPtr_r];
    end
  end

  assign bus.out_data_o  = headData_s;
  assign bus.out_empty_o = fifoEmpty_s;
  assign bus.out_full_o  = fifoFull_s;
  assign bus.out_count_o = fifoCnt_r;
  assign bus.ovf_o       = ovf_r;
  assign bus.stall_o     = stall_s;

endmodule

// File: tb/tb_mac_result_accumulator.sv
// Directed, table-driven bench for mac_result_accumulator (default 32-bit, 16 terms, 16-deep FIFO).
module tb_mac_result_accumulator;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mac_result_accumulator_if #(.DATA_WIDTH(32), .FIFO_DEPTH(16)) bus();

  mac_result_accumulator #(
    .DATA_WIDTH(32), .TERMS_PER_OUTPUT(16), .FIFO_DEPTH(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

`ifdef ACC_RESULT_RELU_EN
  localparam logic [31:0] EXP_RELU_A = 32'h0000_0000;
  localparam logic [31:0] EXP_RELU_B = 32'h0000_0000;
`else
  localparam logic [31:0] EXP_RELU_A = 32'hFFFF_FFEC;
  localparam logic [31:0] EXP_RELU_B = 32'hFFFF_FFFE;
`endif

  typedef struct {
    logic [31:0] t0;
    logic [31:0] t1;
    logic [31:0] bias;
    logic        relu;
    logic [31:0] expData;
    logic        expOvf;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sendTerm(input logic [31:0] d, input logic last);
    bus.res_valid_i = 1'b1;
    bus.res_data_i  = d;
    bus.res_last_i  = last;
    step();
    bus.res_valid_i = 1'b0;
    bus.res_last_i  = 1'b0;
  endtask

  task automatic pop();
    bus.out_rd_i = 1'b1;
    step();
    bus.out_rd_i = 1'b0;
  endtask

  task automatic softClear();
    bus.clear_i = 1'b1;
    step();
    bus.clear_i = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'd10, 32'hFFFF_FFE2, 32'd0, 1'b1, EXP_RELU_A, 1'b0};
    vecs[1] = '{32'd10, 32'hFFFF_FFE2, 32'd0, 1'b0, 32'hFFFF_FFEC, 1'b0};
    vecs[2] = '{32'h7FFF_FFF0, 32'h0000_0020, 32'd0, 1'b0, 32'h7FFF_FFFF, 1'b1};
    vecs[3] = '{32'd100, 32'd200, 32'hFFFF_FFCE, 1'b0, 32'd250, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'h8000_0000, 1'b1};
    vecs[5] = '{32'd5, 32'd5, 32'h7FFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1};
    vecs[6] = '{32'hFFFF_FFFB, 32'd2, 32'd1, 1'b1, EXP_RELU_B, 1'b0};

    reset           = 1'b1;
    bus.clear_i     = 1'b0;
    bus.res_valid_i = 1'b0;
    bus.res_data_i  = 32'd0;
    bus.res_last_i  = 1'b0;
    bus.bias_i      = 32'd0;
    bus.relu_en_i   = 1'b0;
    bus.out_rd_i    = 1'b0;
    step();
    step();
    reset = 1'b0;

    check("rst_empty", {31'd0, bus.out_empty_o}, 32'd1);
    check("rst_full", {31'd0, bus.out_full_o}, 32'd0);
    check("rst_count", {27'd0, bus.out_count_o}, 32'd0);
    check("rst_data", bus.out_data_o, 32'd0);
    check("rst_stall", {31'd0, bus.stall_o}, 32'd0);
    check("rst_ovf", {31'd0, bus.ovf_o}, 32'd0);

    // 16 terms of 1, count-terminated, bias 5 -> 21 two edges after the last term
    bus.bias_i = 32'd5;
    for (int i = 0; i < 16; i++) sendTerm(32'd1, 1'b0);
    check("cnt16_stall_final", {31'd0, bus.stall_o}, 32'd1);
    check("cnt16_empty_n", {31'd0, bus.out_empty_o}, 32'd1);
    step();
    check("cnt16_empty_n1", {31'd0, bus.out_empty_o}, 32'd1);
    step();
    check("cnt16_empty_n2", {31'd0, bus.out_empty_o}, 32'd0);
    check("cnt16_data", bus.out_data_o, 32'd21);
    check("cnt16_count", {27'd0, bus.out_count_o}, 32'd1);
    check("cnt16_ovf", {31'd0, bus.ovf_o}, 32'd0);
    check("cnt16_stall_idle", {31'd0, bus.stall_o}, 32'd0);
    pop();
    check("cnt16_pop_empty", {31'd0, bus.out_empty_o}, 32'd1);
    check("cnt16_pop_data", bus.out_data_o, 32'd0);

    // Table of two-term pixels terminated by res_last
    for (int v = 0; v < 7; v++) begin
      softClear();
      check($sformatf("vec%0d_clr_ovf", v), {31'd0, bus.ovf_o}, 32'd0);
      bus.bias_i    = vecs[v].bias;
      bus.relu_en_i = vecs[v].relu;
      sendTerm(vecs[v].t0, 1'b0);
      sendTerm(vecs[v].t1, 1'b1);
      step();
      step();
      check($sformatf("vec%0d_data", v), bus.out_data_o, vecs[v].expData);
      check($sformatf("vec%0d_count", v), {27'd0, bus.out_count_o}, 32'd1);
      check($sformatf("vec%0d_ovf", v), {31'd0, bus.ovf_o}, {31'd0, vecs[v].expOvf});
      pop();
      check($sformatf("vec%0d_empty", v), {31'd0, bus.out_empty_o}, 32'd1);
      check($sformatf("vec%0d_ovf_sticky", v), {31'd0, bus.ovf_o}, {31'd0, vecs[v].expOvf});
    end

    // Term arriving in FINAL is dropped and flags ovf
    softClear();
    bus.bias_i    = 32'd0;
    bus.relu_en_i = 1'b0;
    sendTerm(32'd3, 1'b0);
    sendTerm(32'd4, 1'b1);
    sendTerm(32'd1000, 1'b0);
    step();
    check("drop_data", bus.out_data_o, 32'd7);
    check("drop_ovf", {31'd0, bus.ovf_o}, 32'd1);
    check("drop_count", {27'd0, bus.out_count_o}, 32'd1);

    // Fill FIFO with 16 single-term pixels, no reads
    softClear();
    for (int i = 0; i < 16; i++) begin
      sendTerm(32'd100 + i, 1'b1);
      step();
      step();
      if (i == 13) check("fill_stall_at14", {31'd0, bus.stall_o}, 32'd0);
      if (i == 14) check("fill_stall_at15", {31'd0, bus.stall_o}, 32'd1);
    end
    check("fill_full", {31'd0, bus.out_full_o}, 32'd1);
    check("fill_count", {27'd0, bus.out_count_o}, 32'd16);
    sendTerm(32'd999, 1'b1);
    step();
    step();
    step();
    check("hold_count", {27'd0, bus.out_count_o}, 32'd16);
    check("hold_stall", {31'd0, bus.stall_o}, 32'd1);
    check("hold_head", bus.out_data_o, 32'd100);
    pop();
    check("pushpop_count", {27'd0, bus.out_count_o}, 32'd16);
    check("pushpop_full", {31'd0, bus.out_full_o}, 32'd1);
    check("pushpop_head", bus.out_data_o, 32'd101);
    for (int i = 1; i < 16; i++) begin
      check($sformatf("drain%0d", i), bus.out_data_o, 32'd100 + i);
      pop();
    end
    check("drain_last", bus.out_data_o, 32'd999);
    pop();
    check("drain_empty", {31'd0, bus.out_empty_o}, 32'd1);
    check("drain_count", {27'd0, bus.out_count_o}, 32'd0);
    pop();
    check("pop_on_empty_count", {27'd0, bus.out_count_o}, 32'd0);

    // Soft clear mid-pixel with 3 FIFO entries
    softClear();
    for (int i = 0; i < 3; i++) begin
      sendTerm(32'd7, 1'b1);
      step();
      step();
    end
    check("clr_pre_count", {27'd0, bus.out_count_o}, 32'd3);
    for (int i = 0; i < 7; i++) sendTerm(32'd1, 1'b0);
    softClear();
    check("clr_count", {27'd0, bus.out_count_o}, 32'd0);
    check("clr_empty", {31'd0, bus.out_empty_o}, 32'd1);
    check("clr_stall", {31'd0, bus.stall_o}, 32'd0);
    check("clr_data", bus.out_data_o, 32'd0);
    for (int i = 0; i < 16; i++) sendTerm(32'd2, 1'b0);
    step();
    step();
    check("clr_after_data", bus.out_data_o, 32'd32);
    check("clr_after_count", {27'd0, bus.out_count_o}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_result_accumulator.md
Name: mac_result_accumulator

Overview:
- Sits directly downstream of the accelerator's 8-lane MAC datapath.
- Sums the per-cycle partial results from the datapath into one output pixel, adds a bias, and optionally applies ReLU.
- Pushes finished pixels into an output FIFO that the Avalon read path drains.
- Drives a stall back to the MAC read state machine so partial sums are never lost.

Parameters:
- DATA_WIDTH, 32, width of partial results, bias and output words (signed two's complement).
- TERMS_PER_OUTPUT, 16, number of partial sums per output pixel (BlockCount x FilterRowSize).
- FIFO_DEPTH, 16, output FIFO entries; must be a power of two, minimum 2.

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- clear_i, in, 1, synchronous soft clear (driven from the accelerator's command reset); same effect as reset.
- res_valid_i, in, 1, partial-sum valid from the MAC pipeline's last stage.
- res_data_i, in, DATA_WIDTH, partial sum.
- res_last_i, in, 1, marks the final partial sum of the current pixel.
- bias_i, in, DATA_WIDTH, bias; sampled in the FINAL state.
- relu_en_i, in, 1, ReLU enable; sampled in the FINAL state.
- stall_o, out, 1, MAC read must not issue new inputs while high.
- out_rd_i, in, 1, pop the FIFO head (Avalon read strobe).
- out_data_o, out, DATA_WIDTH, FIFO head (show-ahead); 0 when empty.
- out_empty_o, out, 1, FIFO empty.
- out_full_o, out, 1, FIFO full.
- out_count_o, out, $clog2(FIFO_DEPTH)+1, FIFO occupancy.
- ovf_o, out, 1, sticky error: a result arrived while stalled, or saturation occurred.

Behaviour:
- Reset or clear_i:
  - state = IDLE; acc = 0; term counter = 0; FIFO pointers and count = 0.
  - out_data_o = 0, out_empty_o = 1, out_full_o = 0, stall_o = 0, ovf_o = 0.
  - Reset asserted mid-pixel discards the partial accumulation and all FIFO contents.
- States: IDLE, ACCUM, FINAL, PUSH.
- IDLE:
  - res_valid_i: acc <= res_data_i, counter <= 1.
  - Next state is FINAL if res_last_i or TERMS_PER_OUTPUT == 1, otherwise ACCUM.
- ACCUM:
  - res_valid_i: acc <= sat(acc + res_data_i), counter + 1.
  - Go to FINAL when res_last_i is high or the counter reaches TERMS_PER_OUTPUT, whichever comes first.
- FINAL: post <= sat(acc + bias_i); if ReLU is active and post is negative, post <= 0. Next state PUSH.
- PUSH:
  - If the FIFO is not full, or out_rd_i pops in the same cycle: write post, clear acc and counter, go to IDLE.
  - Otherwise hold in PUSH.
- Saturation:
  - Signed add clamped to 0x7FFFFFFF / 0x80000000.
  - Any clamp sets ovf_o.
- Latency: a last term sampled at edge N is visible in the FIFO (out_empty_o = 0, count + 1) after edge N+2 when the FIFO has space.
- stall_o = (state == FINAL) || (state == PUSH) || (out_count_o >= FIFO_DEPTH-1).
  - This is combinational from registered state, so the upstream sees it the same cycle.
  - The MAC pipeline can have up to 4 results in flight. The upstream therefore keeps its read gated for MacEngineLatency cycles after the stall rises; its wait-for-calc state already provides this.
- res_valid_i in FINAL or PUSH: the term is dropped and ovf_o is set.
- FIFO:
  - Circular buffer; pointers wrap at FIFO_DEPTH.
  - out_rd_i when empty is ignored.
  - Push and pop in the same cycle leave the count unchanged; this is legal when full.
  - Pop when the count is 1 with no push makes out_empty_o = 1 and out_data_o = 0 after the edge.
- Widths: the counter is $clog2(TERMS_PER_OUTPUT)+1 bits; the accumulator is DATA_WIDTH with a DATA_WIDTH+1 internal sum for overflow detection.

Optional Feature:
- Macro: ACC_RESULT_RELU_EN.
- Defined: relu_en_i is honoured in FINAL as described.
- Undefined:
  - relu_en_i is ignored and post = sat(acc + bias_i) passes unmodified.
  - The ReLU mux is not synthesised; the port remains for interface stability.

Test Plan:
- 16 terms of value 1, no res_last_i, bias 5, relu 0 -> one FIFO entry 21; out_empty_o falls 2 edges after the 16th valid; ovf_o = 0.
- Terms 10, -30 with res_last on the second, bias 0, relu 1 -> entry 0. Same with relu 0 -> 0xFFFFFFEC (-20). Without ACC_RESULT_RELU_EN, relu 1 -> 0xFFFFFFEC.
- Terms 0x7FFFFFF0 and 0x20 (last), bias 0 -> entry 0x7FFFFFFF and ovf_o = 1 sticky until clear_i.
- Fill FIFO_DEPTH=16 pixels with no reads -> stall_o high at count 15; the 17th pixel holds in PUSH. Pulse out_rd_i -> pop and push in the same cycle, count stays 16, first-written value appears at out_data_o first.
- res_valid_i while in FINAL -> term dropped, ovf_o = 1, accumulated pixel value unaffected.
- clear_i asserted after 7 of 16 terms with 3 FIFO entries -> next cycle count 0, out_empty_o = 1; a following 16-term sequence of 2s yields 32.
